// File: rtl/pc_pkg.sv
// Shared types for the fetch-stage PC unit: next-PC source select, boot FSM state, step size.
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_COND,
    SEL_UNCOND,
    SEL_REG,
    SEL_RET
  } pc_sel_t;

  typedef enum logic {
    PC_BOOT,
    PC_RUN
  } pc_state_t;

  function automatic int unsigned instr_step(input int unsigned shift);
    return 32'd1 << shift;
  endfunction

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack; push at full overwrites the oldest entry and pulses overflow_o.
// Top of stack is combinational; push/pop take effect on the next rising edge.
module return_addr_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] push_dat_i,
  output logic [WIDTH-1:0] top_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             overflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    top_idx;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CW'(DEPTH));
  assign overflow_o = push_i & full_o;
  assign top_idx    = wr_ptr_q - PW'(1);
  assign top_o      = mem_q[top_idx];

  // The write pointer wraps naturally, so a push at full lands on the oldest slot.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      if (!full_o) count_d = count_q + CW'(1);
    end else if (pop_i && !empty_o) begin
      wr_ptr_d = wr_ptr_q - PW'(1);
      count_d  = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: priority next-PC select, branch-with-link RAS, boot FSM.
// Next PC registers one edge after the decision; stall freezes PC, RAS and sticky flags.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    INSTR_SHIFT  = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    RAS_DEPTH    = 4
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  stall,
  input  logic                  branchFlag,
  input  logic                  zeroFlag,
  input  logic                  unconditionalBranchFlag,
  input  logic                  linkFlag,
  input  logic                  branchRegFlag,
  input  logic                  returnFlag,
  input  logic [ADDR_WIDTH-1:0] pcOffsetFilled,
  input  logic [ADDR_WIDTH-1:0] regTarget,
  output logic [ADDR_WIDTH-1:0] PC,
  output logic                  pcValid,
  output logic [ADDR_WIDTH-1:0] linkAddr,
  output logic                  rasEmpty,
  output logic                  rasOverflow,
  output logic                  misaligned
);

  localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(instr_step(INSTR_SHIFT));
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK = STEP - ADDR_WIDTH'(1);

  pc_state_t             state_q, state_d;
  pc_sel_t               sel;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  mis_q, mis_d;
  logic                  ovf_q, ovf_d;
  logic                  advance;
  logic                  ras_push, ras_pop, ras_empty, ras_full, ras_ovf;
  logic [ADDR_WIDTH-1:0] ras_top, raw_target, offset_scaled, next_pc;

  assign linkAddr      = pc_q + STEP;
  assign offset_scaled = pcOffsetFilled << INSTR_SHIFT;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) state_q <= PC_BOOT;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PC_BOOT: if (!stall) state_d = PC_RUN;
      default: state_d = PC_RUN;
    endcase
  end

  always_comb begin
    advance = (state_q == PC_RUN) && !stall;
    pcValid = (state_q == PC_RUN);
  end

  always_comb begin
    if (returnFlag)                   sel = SEL_RET;
    else if (branchRegFlag)           sel = SEL_REG;
    else if (unconditionalBranchFlag) sel = SEL_UNCOND;
    else if (branchFlag && zeroFlag)  sel = SEL_COND;
    else                              sel = SEL_SEQ;
  end

  // RET with an empty stack falls back to the register target.
  always_comb begin
    raw_target = regTarget;
    if (sel == SEL_RET && !ras_empty) raw_target = ras_top;
    case (sel)
      SEL_RET, SEL_REG:     next_pc = raw_target & ~LOW_MASK;
      SEL_UNCOND, SEL_COND: next_pc = pc_q + offset_scaled;
      default:              next_pc = linkAddr;
    endcase
  end

  assign ras_push = advance & linkFlag & unconditionalBranchFlag & ~returnFlag & ~branchRegFlag;
  assign ras_pop  = advance & returnFlag;
  assign pc_d     = advance ? next_pc : pc_q;
  assign mis_d    = advance && (sel == SEL_RET || sel == SEL_REG) && |(raw_target & LOW_MASK);
  assign ovf_d    = ovf_q | (ras_ovf & ras_full);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      pc_q  <= RESET_VECTOR;
      mis_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      mis_q <= mis_d;
      ovf_q <= ovf_d;
    end
  end

  return_addr_stack #(
    .WIDTH(ADDR_WIDTH),
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk_i     (clock),
    .rst_ni    (resetN),
    .push_i    (ras_push),
    .pop_i     (ras_pop),
    .push_dat_i(linkAddr),
    .top_o     (ras_top),
    .empty_o   (ras_empty),
    .full_o    (ras_full),
    .overflow_o(ras_ovf)
  );

  assign PC          = pc_q;
  assign rasEmpty    = ras_empty;
  assign rasOverflow = ovf_q;
  assign misaligned  = mis_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized traffic against a queue-based model.
module tb_pc_sequencer;

  localparam int          DEPTH = 4;
  localparam int          STEP  = 4;
  localparam logic [31:0] RV    = 32'h100;

  logic        clock = 1'b0;
  logic        resetN, stall, branchFlag, zeroFlag, unconditionalBranchFlag;
  logic        linkFlag, branchRegFlag, returnFlag;
  logic [31:0] pcOffsetFilled, regTarget;
  logic [31:0] PC, linkAddr;
  logic        pcValid, rasEmpty, rasOverflow, misaligned;

  int n_vec = 0;
  int n_err = 0;

  // Reference state
  logic [31:0] m_pc;
  logic        m_valid, m_mis, m_ovf;
  logic [31:0] m_ras[$];

  always #5 clock = ~clock;

  pc_sequencer #(
    .ADDR_WIDTH(32), .INSTR_SHIFT(2), .RESET_VECTOR(RV), .RAS_DEPTH(DEPTH)
  ) dut (
    .clock(clock), .resetN(resetN), .stall(stall), .branchFlag(branchFlag),
    .zeroFlag(zeroFlag), .unconditionalBranchFlag(unconditionalBranchFlag),
    .linkFlag(linkFlag), .branchRegFlag(branchRegFlag), .returnFlag(returnFlag),
    .pcOffsetFilled(pcOffsetFilled), .regTarget(regTarget), .PC(PC),
    .pcValid(pcValid), .linkAddr(linkAddr), .rasEmpty(rasEmpty),
    .rasOverflow(rasOverflow), .misaligned(misaligned)
  );

  task automatic clear_inputs();
    stall = 0; branchFlag = 0; zeroFlag = 0; unconditionalBranchFlag = 0;
    linkFlag = 0; branchRegFlag = 0; returnFlag = 0;
    pcOffsetFilled = '0; regTarget = '0;
  endtask

  task automatic model_reset();
    m_pc = RV; m_valid = 0; m_mis = 0; m_ovf = 0;
    m_ras.delete();
  endtask

  // Advance the model from the current inputs, then let the DUT take the same edge.
  task automatic tick();
    logic [31:0] t;
    if (!m_valid) begin
      if (!stall) m_valid = 1;
      m_mis = 0;
    end else if (stall) begin
      m_mis = 0;
    end else begin
      m_mis = 0;
      if (returnFlag || branchRegFlag) begin
        t = regTarget;
        if (returnFlag && m_ras.size() > 0) t = m_ras.pop_back();
        m_mis = (t % STEP) != 0;
        m_pc  = t - (t % STEP);
      end else if (unconditionalBranchFlag) begin
        if (linkFlag) begin
          m_ras.push_back(m_pc + STEP);
          if (m_ras.size() > DEPTH) begin
            void'(m_ras.pop_front());
            m_ovf = 1;
          end
        end
        m_pc = m_pc + pcOffsetFilled * STEP;
      end else if (branchFlag && zeroFlag) begin
        m_pc = m_pc + pcOffsetFilled * STEP;
      end else begin
        m_pc = m_pc + STEP;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic go_to(input logic [31:0] addr);
    clear_inputs();
    branchRegFlag = 1; regTarget = addr;
    tick();
    clear_inputs();
    n_vec++;
    if (PC !== addr) begin n_err++; $display("FAIL go_to PC=%h expected=%h", PC, addr); end
  endtask

  task automatic test_reset();
    clear_inputs();
    resetN = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    n_vec++; if (PC !== RV) begin n_err++; $display("FAIL reset_pc PC=%h expected=%h", PC, RV); end
    n_vec++; if (pcValid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b expected=0", pcValid); end
    n_vec++; if (rasEmpty !== 1'b1) begin n_err++; $display("FAIL reset_rasempty got=%b expected=1", rasEmpty); end
    n_vec++; if (rasOverflow !== 1'b0 || misaligned !== 1'b0) begin
      n_err++; $display("FAIL reset_flags ovf=%b mis=%b expected=0,0", rasOverflow, misaligned); end
    resetN = 1;
    tick();
    n_vec++; if (pcValid !== 1'b1 || PC !== RV) begin
      n_err++; $display("FAIL boot valid=%b PC=%h expected=1,%h", pcValid, PC, RV); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h104; exp_pc[1] = 32'h108; exp_pc[2] = 32'h10C;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (PC !== exp_pc[i]) begin n_err++; $display("FAIL seq%0d PC=%h expected=%h", i, PC, exp_pc[i]); end
    end
  endtask

  task automatic test_cond_branch();
    go_to(32'h200);
    branchFlag = 1; zeroFlag = 0; pcOffsetFilled = 32'hFFFF_FFFE;
    tick();
    n_vec++; if (PC !== 32'h204) begin n_err++; $display("FAIL cond_not_taken PC=%h expected=00000204", PC); end
    go_to(32'h200);
    branchFlag = 1; zeroFlag = 1; pcOffsetFilled = 32'hFFFF_FFFE;
    tick();
    n_vec++; if (PC !== 32'h1F8) begin n_err++; $display("FAIL cond_taken PC=%h expected=000001f8", PC); end
  endtask

  task automatic test_bl_ret();
    go_to(32'h40);
    unconditionalBranchFlag = 1; linkFlag = 1; pcOffsetFilled = 32'h10;
    #1;
    n_vec++; if (linkAddr !== 32'h44) begin n_err++; $display("FAIL link_addr got=%h expected=00000044", linkAddr); end
    tick();
    n_vec++; if (PC !== 32'h80 || rasEmpty !== 1'b0) begin
      n_err++; $display("FAIL bl PC=%h empty=%b expected=00000080,0", PC, rasEmpty); end
    clear_inputs();
    returnFlag = 1; regTarget = 32'hDEAD0;
    tick();
    n_vec++; if (PC !== 32'h44 || rasEmpty !== 1'b1 || misaligned !== 1'b0) begin
      n_err++; $display("FAIL ret PC=%h empty=%b mis=%b expected=00000044,1,0", PC, rasEmpty, misaligned); end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] exp;
    go_to(32'h1000);
    for (int i = 0; i < 5; i++) begin
      unconditionalBranchFlag = 1; linkFlag = 1; pcOffsetFilled = 32'h10;
      tick();
      exp = 32'h1000 + 32'h40 * (i + 1);
      n_vec++; if (PC !== exp || rasOverflow !== (i == 4)) begin
        n_err++; $display("FAIL bl_nest%0d PC=%h ovf=%b expected=%h,%b", i, PC, rasOverflow, exp, i == 4); end
    end
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      returnFlag = 1; regTarget = 32'h2000;
      tick();
      exp = 32'h1000 + 32'h40 * (4 - i) + 32'h4;
      n_vec++; if (PC !== exp) begin n_err++; $display("FAIL ret_lifo%0d PC=%h expected=%h", i, PC, exp); end
    end
    tick();
    n_vec++; if (PC !== 32'h2000 || rasEmpty !== 1'b1) begin
      n_err++; $display("FAIL ret_empty PC=%h empty=%b expected=00002000,1", PC, rasEmpty); end
    clear_inputs();
  endtask

  task automatic test_stall_priority();
    stall = 1; branchFlag = 1; zeroFlag = 1; unconditionalBranchFlag = 1; linkFlag = 1;
    branchRegFlag = 1; returnFlag = 1; pcOffsetFilled = 32'h5; regTarget = 32'h555;
    tick();
    n_vec++; if (PC !== 32'h2000 || rasEmpty !== 1'b1 || misaligned !== 1'b0) begin
      n_err++; $display("FAIL stall PC=%h empty=%b mis=%b expected=00002000,1,0", PC, rasEmpty, misaligned); end
    stall = 0; regTarget = 32'h303;
    tick();
    n_vec++; if (PC !== 32'h300 || misaligned !== 1'b1 || rasEmpty !== 1'b1) begin
      n_err++; $display("FAIL prio PC=%h mis=%b empty=%b expected=00000300,1,1", PC, misaligned, rasEmpty); end
    n_vec++; if (rasOverflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got=%b expected=1", rasOverflow); end
    clear_inputs();
    tick();
    n_vec++; if (PC !== 32'h304 || misaligned !== 1'b0) begin
      n_err++; $display("FAIL mis_pulse PC=%h mis=%b expected=00000304,0", PC, misaligned); end
  endtask

  task automatic test_wrap_reset();
    go_to(32'hFFFF_FFFC);
    tick();
    n_vec++; if (PC !== 32'h0) begin n_err++; $display("FAIL wrap PC=%h expected=00000000", PC); end
    unconditionalBranchFlag = 1; linkFlag = 1; pcOffsetFilled = 32'h4;
    tick();
    clear_inputs();
    n_vec++; if (rasEmpty !== 1'b0) begin n_err++; $display("FAIL pre_reset_push empty=%b expected=0", rasEmpty); end
    @(negedge clock);
    resetN = 0;
    model_reset();
    #1;
    n_vec++; if (PC !== RV || pcValid !== 1'b0 || rasEmpty !== 1'b1 || rasOverflow !== 1'b0) begin
      n_err++; $display("FAIL midreset PC=%h valid=%b empty=%b ovf=%b expected=%h,0,1,0",
                        PC, pcValid, rasEmpty, rasOverflow, RV); end
    @(posedge clock);
    #1;
    resetN = 1;
    stall = 1;
    tick();
    n_vec++; if (pcValid !== 1'b0) begin n_err++; $display("FAIL boot_stall valid=%b expected=0", pcValid); end
    stall = 0;
    tick();
    n_vec++; if (pcValid !== 1'b1 || PC !== RV) begin
      n_err++; $display("FAIL reboot valid=%b PC=%h expected=1,%h", pcValid, PC, RV); end
  endtask

  task automatic test_random();
    int errs_before;
    for (int i = 0; i < 600; i++) begin
      errs_before = n_err;
      stall                   = ($urandom_range(0, 7) == 0);
      returnFlag              = ($urandom_range(0, 5) == 0);
      branchRegFlag           = ($urandom_range(0, 9) == 0);
      unconditionalBranchFlag = ($urandom_range(0, 4) == 0);
      linkFlag                = ($urandom_range(0, 1) == 1);
      branchFlag              = ($urandom_range(0, 3) == 0);
      zeroFlag                = ($urandom_range(0, 1) == 1);
      pcOffsetFilled          = 32'($urandom_range(0, 255)) - 32'd128;
      regTarget               = $urandom;
      if ($urandom_range(0, 1) == 1) regTarget = regTarget & 32'hFFFF_FFFC;
      #1;
      n_vec++; if (linkAddr !== m_pc + 32'd4) begin
        n_err++; $display("FAIL rnd_link%0d got=%h expected=%h", i, linkAddr, m_pc + 32'd4); end
      tick();
      n_vec++; if (PC !== m_pc || pcValid !== m_valid) begin
        n_err++; $display("FAIL rnd_pc%0d PC=%h valid=%b expected=%h,%b", i, PC, pcValid, m_pc, m_valid); end
      n_vec++; if (rasEmpty !== (m_ras.size() == 0) || rasOverflow !== m_ovf || misaligned !== m_mis) begin
        n_err++; $display("FAIL rnd_flags%0d empty=%b ovf=%b mis=%b expected=%b,%b,%b", i, rasEmpty,
                          rasOverflow, misaligned, m_ras.size() == 0, m_ovf, m_mis); end
      if (n_err - errs_before != 0 && n_err > 20) break;
    end
    clear_inputs();
  endtask

  initial begin
    resetN = 0;
    clear_inputs();
    model_reset();
    test_reset();
    test_sequential();
    test_cond_branch();
    test_bl_ret();
    test_ras_overflow();
    test_stall_priority();
    test_wrap_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
